// File: rtl/apb_prio_arbiter.sv
// Purpose: APB-programmable priority arbiter; one-hot grant of a shared resource among NUM_REQ requesters.
// Latency: grant registers two edges after eligibility is first seen (IDLE + ARB); APB is zero wait state.
// Backpressure: none; pready_o is combinational on the access phase and the grant is held until release or timeout.
module apb_prio_arbiter #(
    parameter int NUM_REQ = 8,
    parameter int PRIO_W  = 4,
    parameter int ID_W    = 3
) (
    input  logic               pclk_i,
    input  logic               prst_n_i,
    input  logic               psel_i,
    input  logic               penable_i,
    input  logic               pwrite_i,
    input  logic [7:0]         paddr_i,
    input  logic [7:0]         pwdata_i,
    output logic [7:0]         prdata_o,
    output logic               pready_o,
    output logic               pslverr_o,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               done_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    gnt_id_o,
    output logic               gnt_valid_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARB   = 2'd1;
    localparam logic [1:0] ST_GRANT = 2'd2;

    localparam logic [7:0] A_MASK_LO = 8'h10;
    localparam logic [7:0] A_MASK_HI = 8'h11;
    localparam logic [7:0] A_CTRL    = 8'h12;
    localparam logic [7:0] A_STATUS  = 8'h13;
    localparam logic [7:0] A_TIMEOUT = 8'h14;
    localparam logic [7:0] A_FLAGS   = 8'h15;
    localparam logic [7:0] A_GNT_CNT = 8'h16;

    localparam int               CW      = ID_W + 1;
    localparam logic [CW-1:0]    NREQ_C  = CW'(NUM_REQ);
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_REQ - 1);
    localparam logic [7:0]       NREQ_A  = 8'(NUM_REQ);

    // Register state
    logic [PRIO_W-1:0]  prio_q [NUM_REQ];
    logic [PRIO_W-1:0]  prio_d [NUM_REQ];
    logic [NUM_REQ-1:0] mask_q, mask_d;
    logic               ctrl_en_q, ctrl_en_d;
    logic               ctrl_rr_q, ctrl_rr_d;
    logic [7:0]         timeout_q, timeout_d;
    logic               to_sticky_q, to_sticky_d;
    logic [7:0]         gnt_cnt_q, gnt_cnt_d;

    // Arbitration state
    logic [1:0]         state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
    logic               gnt_vld_q, gnt_vld_d;
    logic [7:0]         hold_q, hold_d;
    logic               to_set;

    // APB decode
    logic        apb_access;
    logic        addr_prio;
    logic        addr_mapped;
    logic        addr_ro;
    logic        apb_err;
    logic        wr_ok;
    logic [7:0]  rd_val;
    logic [15:0] mask_ext;
    logic [15:0] mask_ext_d;

    assign apb_access = psel_i & penable_i;
    assign addr_prio  = (paddr_i < NREQ_A);
    assign mask_ext   = 16'(mask_q);

    always_comb begin
        rd_val      = '0;
        addr_mapped = 1'b0;
        addr_ro     = 1'b0;
        if (addr_prio) begin
            addr_mapped = 1'b1;
            rd_val      = 8'(prio_q[paddr_i[ID_W-1:0]]);
        end else begin
            case (paddr_i)
                A_MASK_LO: begin
                    addr_mapped = 1'b1;
                    rd_val      = mask_ext[7:0];
                end
                A_MASK_HI: begin
                    addr_mapped = (NUM_REQ > 8);
                    rd_val      = mask_ext[15:8];
                end
                A_CTRL: begin
                    addr_mapped = 1'b1;
                    rd_val      = {6'b0, ctrl_rr_q, ctrl_en_q};
                end
                A_STATUS: begin
                    addr_mapped = 1'b1;
                    addr_ro     = 1'b1;
                    rd_val      = {gnt_vld_q, 3'b0, 4'(gnt_id_q)};
                end
                A_TIMEOUT: begin
                    addr_mapped = 1'b1;
                    rd_val      = timeout_q;
                end
                A_FLAGS: begin
                    addr_mapped = 1'b1;
                    rd_val      = {7'b0, to_sticky_q};
                end
                A_GNT_CNT: begin
                    addr_mapped = 1'b1;
                    addr_ro     = 1'b1;
                    rd_val      = gnt_cnt_q;
                end
                default: ;
            endcase
        end
    end

    assign apb_err   = apb_access & (~addr_mapped | (pwrite_i & addr_ro));
    assign wr_ok     = apb_access & pwrite_i & ~apb_err;
    assign pready_o  = apb_access;
    assign pslverr_o = apb_err;
    assign prdata_o  = (apb_access & ~pwrite_i & ~apb_err) ? rd_val : 8'h00;

    // Register writes; a timeout firing in the same cycle as the W1C wins
    always_comb begin
        prio_d      = prio_q;
        mask_ext_d  = mask_ext;
        ctrl_en_d   = ctrl_en_q;
        ctrl_rr_d   = ctrl_rr_q;
        timeout_d   = timeout_q;
        to_sticky_d = to_sticky_q;
        if (wr_ok) begin
            if (addr_prio) begin
                prio_d[paddr_i[ID_W-1:0]] = pwdata_i[PRIO_W-1:0];
            end else begin
                case (paddr_i)
                    A_MASK_LO: mask_ext_d[7:0]  = pwdata_i;
                    A_MASK_HI: mask_ext_d[15:8] = pwdata_i;
                    A_CTRL: begin
                        ctrl_en_d = pwdata_i[0];
                        ctrl_rr_d = pwdata_i[1];
                    end
                    A_TIMEOUT: timeout_d = pwdata_i;
                    A_FLAGS:   if (pwdata_i[0]) to_sticky_d = 1'b0;
                    default: ;
                endcase
            end
        end
        if (to_set) begin
            to_sticky_d = 1'b1;
        end
        mask_d = mask_ext_d[NUM_REQ-1:0];
    end

    // Winner search: scan in circular order from start_id, keep first of the highest priority
    logic [NUM_REQ-1:0] elig;
    logic [ID_W-1:0]    start_id;
    logic [ID_W-1:0]    win_id;
    logic [PRIO_W-1:0]  win_prio;
    logic               win_found;
    logic [CW-1:0]      cand;
    logic [ID_W-1:0]    cand_id;

    always_comb begin
        elig      = ctrl_en_q ? (req_i & mask_q) : '0;
        start_id  = '0;
        if (ctrl_rr_q) begin
            start_id = (rr_ptr_q == LAST_ID) ? '0 : rr_ptr_q + 1'b1;
        end
        win_found = 1'b0;
        win_id    = '0;
        win_prio  = '0;
        cand      = '0;
        cand_id   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = CW'(start_id) + CW'(k);
            if (cand >= NREQ_C) begin
                cand = cand - NREQ_C;
            end
            cand_id = cand[ID_W-1:0];
            if (elig[cand_id] && (!win_found || (prio_q[cand_id] > win_prio))) begin
                win_found = 1'b1;
                win_id    = cand_id;
                win_prio  = prio_q[cand_id];
            end
        end
    end

    logic grant_release;
    logic grant_tmo;

    assign grant_release = done_i | ~req_i[gnt_id_q];
    assign grant_tmo     = (timeout_q != 8'h00) && (hold_q == (timeout_q - 8'd1));

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        gnt_vld_d = gnt_vld_q;
        hold_d    = hold_q;
        gnt_cnt_d = gnt_cnt_q;
        to_set    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|elig) begin
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if (win_found) begin
                    state_d         = ST_GRANT;
                    gnt_d           = '0;
                    gnt_d[win_id]   = 1'b1;
                    gnt_id_d        = win_id;
                    gnt_vld_d       = 1'b1;
                    rr_ptr_d        = win_id;
                    gnt_cnt_d       = gnt_cnt_q + 8'd1;
                    hold_d          = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (grant_release || grant_tmo) begin
                    state_d   = ST_IDLE;
                    gnt_d     = '0;
                    gnt_id_d  = '0;
                    gnt_vld_d = 1'b0;
                    to_set    = grant_tmo & ~grant_release;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                gnt_d     = '0;
                gnt_id_d  = '0;
                gnt_vld_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge pclk_i or negedge prst_n_i) begin
        if (!prst_n_i) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                prio_q[i] <= '0;
            end
            mask_q      <= '0;
            ctrl_en_q   <= 1'b0;
            ctrl_rr_q   <= 1'b0;
            timeout_q   <= 8'h00;
            to_sticky_q <= 1'b0;
            gnt_cnt_q   <= 8'h00;
            state_q     <= ST_IDLE;
            rr_ptr_q    <= LAST_ID;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_vld_q   <= 1'b0;
            hold_q      <= 8'h00;
        end else begin
            prio_q      <= prio_d;
            mask_q      <= mask_d;
            ctrl_en_q   <= ctrl_en_d;
            ctrl_rr_q   <= ctrl_rr_d;
            timeout_q   <= timeout_d;
            to_sticky_q <= to_sticky_d;
            gnt_cnt_q   <= gnt_cnt_d;
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_vld_q   <= gnt_vld_d;
            hold_q      <= hold_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_id_o    = gnt_id_q;
    assign gnt_valid_o = gnt_vld_q;

endmodule

// File: tb/tb_apb_prio_arbiter.sv
// Directed bench for apb_prio_arbiter: register vector table plus hand-timed arbitration sequences.
module tb_apb_prio_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       psel, penable, pwrite;
    logic [7:0] paddr, pwdata, prdata;
    logic       pready, pslverr;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_vld;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp_rd;
        logic       exp_err;
    } vec_t;

    vec_t vecs[$];
    int   n_rst;

    apb_prio_arbiter #(.NUM_REQ(8), .PRIO_W(4), .ID_W(3)) dut (
        .pclk_i      (clk),
        .prst_n_i    (rst_n),
        .psel_i      (psel),
        .penable_i   (penable),
        .pwrite_i    (pwrite),
        .paddr_i     (paddr),
        .pwdata_i    (pwdata),
        .prdata_o    (prdata),
        .pready_o    (pready),
        .pslverr_o   (pslverr),
        .req_i       (req),
        .done_i      (done),
        .gnt_o       (gnt),
        .gnt_id_o    (gnt_id),
        .gnt_valid_o (gnt_vld)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 two edges later.
    task automatic apb(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                       output logic [7:0] rd, output logic err);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        #1;
        chk("pready_setup", pready, 0);
        @(posedge clk); #1;
        penable = 1'b1;
        #1;
        rd  = prdata;
        err = pslverr;
        chk("pready_access", pready, 1);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr_reg(input logic [7:0] addr, input logic [7:0] data);
        logic [7:0] rd;
        logic       err;
        apb(1'b1, addr, data, rd, err);
        chk($sformatf("wr_err@%02h", addr), err, 0);
    endtask

    task automatic rd_reg(input string name, input logic [7:0] addr, input logic [7:0] exp);
        logic [7:0] rd;
        logic       err;
        apb(1'b0, addr, 8'h00, rd, err);
        chk({name, "_err"}, err, 0);
        chk(name, rd, exp);
    endtask

    task automatic add(input logic wr, input logic [7:0] addr, input logic [7:0] data,
                       input logic [7:0] exp_rd, input logic exp_err);
        vec_t v;
        v.wr = wr; v.addr = addr; v.data = data; v.exp_rd = exp_rd; v.exp_err = exp_err;
        vecs.push_back(v);
    endtask

    task automatic run_vecs(input int lo, input int hi);
        logic [7:0] rd;
        logic       err;
        for (int i = lo; i <= hi; i++) begin
            apb(vecs[i].wr, vecs[i].addr, vecs[i].data, rd, err);
            chk($sformatf("vec%0d_err@%02h", i, vecs[i].addr), err, vecs[i].exp_err);
            if (!vecs[i].wr) begin
                chk($sformatf("vec%0d_rd@%02h", i, vecs[i].addr), rd, vecs[i].exp_rd);
            end
        end
    endtask

    int rr_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 8'h00; pwdata = 8'h00; req = 8'h00; done = 1'b0;

        // Reset-default reads first, then write/readback and error cases, then restore
        for (int i = 0; i < 8; i++) add(1'b0, 8'(i), 8'h00, 8'h00, 1'b0);
        add(1'b0, 8'h10, 8'h00, 8'h00, 1'b0);
        add(1'b0, 8'h11, 8'h00, 8'h00, 1'b1);
        add(1'b0, 8'h12, 8'h00, 8'h00, 1'b0);
        add(1'b0, 8'h13, 8'h00, 8'h00, 1'b0);
        add(1'b0, 8'h14, 8'h00, 8'h00, 1'b0);
        add(1'b0, 8'h15, 8'h00, 8'h00, 1'b0);
        add(1'b0, 8'h16, 8'h00, 8'h00, 1'b0);
        add(1'b0, 8'h20, 8'h00, 8'h00, 1'b1);
        n_rst = vecs.size();
        add(1'b1, 8'h13, 8'hFF, 8'h00, 1'b1);
        add(1'b1, 8'h16, 8'h55, 8'h00, 1'b1);
        add(1'b0, 8'h16, 8'h00, 8'h00, 1'b0);
        add(1'b1, 8'h03, 8'hFA, 8'h00, 1'b0);
        add(1'b0, 8'h03, 8'h00, 8'h0A, 1'b0);
        add(1'b1, 8'h10, 8'hA5, 8'h00, 1'b0);
        add(1'b0, 8'h10, 8'h00, 8'hA5, 1'b0);
        add(1'b1, 8'h12, 8'hFF, 8'h00, 1'b0);
        add(1'b0, 8'h12, 8'h00, 8'h03, 1'b0);
        add(1'b1, 8'h14, 8'h37, 8'h00, 1'b0);
        add(1'b0, 8'h14, 8'h00, 8'h37, 1'b0);
        add(1'b1, 8'h15, 8'h01, 8'h00, 1'b0);
        add(1'b0, 8'h15, 8'h00, 8'h00, 1'b0);
        add(1'b1, 8'h20, 8'h12, 8'h00, 1'b1);
        add(1'b1, 8'h11, 8'hFF, 8'h00, 1'b1);
        add(1'b0, 8'h08, 8'h00, 8'h00, 1'b1);
        add(1'b1, 8'h03, 8'h00, 8'h00, 1'b0);
        add(1'b1, 8'h10, 8'h00, 8'h00, 1'b0);
        add(1'b1, 8'h12, 8'h00, 8'h00, 1'b0);
        add(1'b1, 8'h14, 8'h00, 8'h00, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_vld", gnt_vld, 0);
        chk("rst_id", gnt_id, 0);
        chk("idle_pready", pready, 0);
        chk("idle_prdata", prdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);

        run_vecs(0, vecs.size() - 1);

        // Priority win: 6 (prio 9) beats 2 (prio 5)
        wr_reg(8'h02, 8'h05);
        wr_reg(8'h06, 8'h09);
        wr_reg(8'h10, 8'hFF);
        wr_reg(8'h12, 8'h01);
        req = 8'h44;
        chk("pw_vld_e0", gnt_vld, 0);
        tick(1);
        chk("pw_vld_arb", gnt_vld, 0);
        tick(1);
        chk("pw_gnt", gnt, 8'h40);
        chk("pw_id", gnt_id, 6);
        chk("pw_vld", gnt_vld, 1);
        rd_reg("pw_status", 8'h13, 8'h86);
        done = 1'b1;
        tick(1);
        done = 1'b0;
        req = 8'h00;
        chk("pw_rel_gnt", gnt, 0);
        chk("pw_rel_vld", gnt_vld, 0);
        rd_reg("pw_cnt", 8'h16, 8'h01);

        // Round-robin ties
        for (int i = 0; i < 8; i++) wr_reg(8'(i), 8'h03);
        wr_reg(8'h12, 8'h03);
        req = 8'h0F;
        tick(2);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rr_vld%0d", k), gnt_vld, 1);
            chk($sformatf("rr_id%0d", k), gnt_id, rr_order[k]);
            done = 1'b1;
            tick(1);
            done = 1'b0;
            chk($sformatf("rr_gap_a%0d", k), gnt_vld, 0);
            tick(1);
            chk($sformatf("rr_gap_b%0d", k), gnt_vld, 0);
            tick(1);
        end
        chk("rr_extra_id", gnt_id, 1);
        req = 8'h00;
        tick(1);
        chk("rr_drop", gnt_vld, 0);

        // Lowest-index ties
        wr_reg(8'h12, 8'h01);
        req = 8'h0F;
        tick(2);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("li_vld%0d", k), gnt_vld, 1);
            chk($sformatf("li_id%0d", k), gnt_id, 0);
            done = 1'b1;
            tick(1);
            done = 1'b0;
            tick(2);
        end
        req = 8'h00;
        tick(2);
        rd_reg("cnt_after_ties", 8'h16, 8'd11);

        // Mask and enable
        wr_reg(8'h10, 8'hFE);
        req = 8'h01;
        tick(6);
        chk("mask_block", gnt_vld, 0);
        req = 8'h00;
        wr_reg(8'h12, 8'h00);
        wr_reg(8'h10, 8'hFF);
        req = 8'hFF;
        tick(6);
        chk("en_block", gnt_vld, 0);
        req = 8'h00;
        wr_reg(8'h12, 8'h01);
        req = 8'h08;
        tick(2);
        chk("m3_id", gnt_id, 3);
        wr_reg(8'h10, 8'h00);
        tick(3);
        chk("m3_hold_vld", gnt_vld, 1);
        chk("m3_hold_gnt", gnt, 8'h08);
        done = 1'b1;
        tick(1);
        done = 1'b0;
        req = 8'h00;
        chk("m3_rel", gnt_vld, 0);

        // Timeout after 4 held cycles, then re-grant after the gap
        wr_reg(8'h10, 8'hFF);
        wr_reg(8'h14, 8'h04);
        req = 8'h02;
        tick(2);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("to_hold%0d", c), gnt_vld, 1);
            tick(1);
        end
        chk("to_expire", gnt_vld, 0);
        tick(1);
        chk("to_gap", gnt_vld, 0);
        tick(1);
        chk("to_regrant_vld", gnt_vld, 1);
        chk("to_regrant_id", gnt_id, 1);
        req = 8'h00;
        tick(1);
        chk("to_drop", gnt_vld, 0);
        rd_reg("to_flag", 8'h15, 8'h01);
        wr_reg(8'h15, 8'h01);
        rd_reg("to_flag_clr", 8'h15, 8'h00);

        // done_i in the timeout cycle: release wins, no sticky
        req = 8'h02;
        tick(2);
        tick(3);
        chk("tc_vld_last", gnt_vld, 1);
        done = 1'b1;
        tick(1);
        done = 1'b0;
        req = 8'h00;
        chk("tc_rel", gnt_vld, 0);
        rd_reg("tc_flag", 8'h15, 8'h00);

        // Request drop releases the grant
        wr_reg(8'h14, 8'h00);
        req = 8'h20;
        tick(2);
        chk("drop_id", gnt_id, 5);
        tick(2);
        chk("drop_hold", gnt, 8'h20);
        req = 8'h00;
        tick(1);
        chk("drop_gnt", gnt, 0);

        // Asynchronous reset mid-grant
        req = 8'h20;
        tick(2);
        chk("ar_pre", gnt_vld, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_gnt", gnt, 0);
        chk("ar_vld", gnt_vld, 0);
        req = 8'h00;
        tick(2);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        run_vecs(0, n_rst - 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
